// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAdd  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Nibble index width; a single-nibble adder still needs a 1-bit index.
  function automatic int unsigned idx_width(int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/bit_ripple_carry_adder.sv
// Combinational 4-bit ripple-carry adder used as the nibble datapath.
module bit_ripple_carry_adder
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit ripple adder over NIBBLES cycles, LSB nibble first,
// with valid/ready handshakes on both sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IdxW    = idx_width(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d, sum_shift;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              zero_q, zero_d;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  bit_ripple_carry_adder u_rca (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Each nibble result enters at the MSB end, so after NIBBLES shifts it sits in place.
  if (WIDTH == NIBBLE_W) begin : g_single
    assign sum_shift = nib_sum;
  end else begin : g_multi
    assign sum_shift = {nib_sum, sum_q[WIDTH-1:NIBBLE_W]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        carry_d = nib_cout;
        sum_d   = sum_shift;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          cout_d  = nib_cout;
          zero_d  = (sum_shift == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH = 4, 16 and 32.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_drv, out_ready_drv, cin_drv;
  logic [31:0] a_drv, b_drv;
  int          sel_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic        in_ready4, out_valid4, cout4, zero4, busy4;
  logic [3:0]  sum4;
  logic        in_ready16, out_valid16, cout16, zero16, busy16;
  logic [15:0] sum16;
  logic        in_ready32, out_valid32, cout32, zero32, busy32;
  logic [31:0] sum32;

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_drv && sel_w == 4), .in_ready(in_ready4),
    .a(a_drv[3:0]), .b(b_drv[3:0]), .cin(cin_drv), .out_valid(out_valid4),
    .out_ready(out_ready_drv), .sum(sum4), .cout(cout4), .zero(zero4), .busy(busy4)
  );

  nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_drv && sel_w == 16), .in_ready(in_ready16),
    .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin_drv), .out_valid(out_valid16),
    .out_ready(out_ready_drv), .sum(sum16), .cout(cout16), .zero(zero16), .busy(busy16)
  );

  nibble_serial_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_drv && sel_w == 32), .in_ready(in_ready32),
    .a(a_drv), .b(b_drv), .cin(cin_drv), .out_valid(out_valid32),
    .out_ready(out_ready_drv), .sum(sum32), .cout(cout32), .zero(zero32), .busy(busy32)
  );

  logic        in_ready_o, out_valid_o, cout_o, zero_o, busy_o;
  logic [31:0] sum_o;

  always_comb begin
    in_ready_o  = in_ready16;
    out_valid_o = out_valid16;
    cout_o      = cout16;
    zero_o      = zero16;
    busy_o      = busy16;
    sum_o       = {16'h0, sum16};
    if (sel_w == 4) begin
      in_ready_o = in_ready4; out_valid_o = out_valid4; cout_o = cout4;
      zero_o = zero4; busy_o = busy4; sum_o = {28'h0, sum4};
    end else if (sel_w == 32) begin
      in_ready_o = in_ready32; out_valid_o = out_valid32; cout_o = cout32;
      zero_o = zero32; busy_o = busy32; sum_o = sum32;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (w=%0d, t=%0t)", tag, got, exp, sel_w, $time);
    end
  endtask

  // Waits for out_valid after the acceptance edge and checks the edge count.
  task automatic wait_result(input int nib);
    int n;
    n = 0;
    while (!out_valid_o && n <= 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, nib);
  endtask

  task automatic run(input int w, input logic [31:0] av, input logic [31:0] bv, input logic c,
                     input logic [31:0] es, input logic ec, input logic ez, input int stall);
    sel_w         = w;
    a_drv         = av;
    b_drv         = bv;
    cin_drv       = c;
    out_ready_drv = (stall == 0);
    check("idle_in_ready", in_ready_o, 1);
    in_valid_drv = 1'b1;
    @(posedge clk); #1;
    in_valid_drv = 1'b0;
    a_drv   = ~av;
    b_drv   = ~bv;
    cin_drv = ~c;
    check("acc_busy", busy_o, 1);
    check("acc_in_ready", in_ready_o, 0);
    wait_result(w / 4);
    for (int i = 0; i < stall; i++) begin
      check("stall_sum", sum_o, es);
      check("stall_cout", cout_o, ec);
      check("stall_valid", out_valid_o, 1);
      check("stall_in_ready", in_ready_o, 0);
      @(posedge clk); #1;
    end
    out_ready_drv = 1'b1;
    check("sum", sum_o, es);
    check("cout", cout_o, ec);
    check("zero", zero_o, ez);
    check("out_valid", out_valid_o, 1);
    @(posedge clk); #1;
    out_ready_drv = 1'b0;
    check("valid_drop", out_valid_o, 0);
    check("ready_back", in_ready_o, 1);
    check("sum_kept", sum_o, es);
  endtask

  initial begin
    rst = 1'b1;
    in_valid_drv = 1'b0; out_ready_drv = 1'b0; cin_drv = 1'b0;
    a_drv = '0; b_drv = '0; sel_w = 16;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_sum", sum_o, 0);
    check("rst_cout", cout_o, 0);
    check("rst_zero", zero_o, 0);
    check("rst_busy", busy_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // WIDTH=16 directed vectors
    run(16, 32'h1234, 32'h4321, 1'b0, 32'h5555, 1'b0, 1'b0, 0);
    run(16, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b1, 0);
    run(16, 32'hFFFF, 32'h0000, 1'b1, 32'h0000, 1'b1, 1'b1, 0);
    run(16, 32'h8000, 32'h8000, 1'b0, 32'h0000, 1'b1, 1'b1, 6);
    run(16, 32'hABCD, 32'h1234, 1'b1, 32'hBE02, 1'b0, 1'b0, 2);

    // in_valid held through ADD/DONE; second operands wait for IDLE
    sel_w = 16; a_drv = 32'h00FF; b_drv = 32'h0001; cin_drv = 1'b0;
    out_ready_drv = 1'b1; in_valid_drv = 1'b1;
    @(posedge clk); #1;
    a_drv = 32'h1234; b_drv = 32'h1111;
    wait_result(4);
    check("hold_sum1", sum_o, 32'h0100);
    check("hold_cout1", cout_o, 0);
    @(posedge clk); #1;
    check("hs_only_ready", in_ready_o, 1);
    check("hs_only_busy", busy_o, 0);
    @(posedge clk); #1;
    in_valid_drv = 1'b0;
    check("second_acc_busy", busy_o, 1);
    wait_result(4);
    check("hold_sum2", sum_o, 32'h2345);
    @(posedge clk); #1;
    out_ready_drv = 1'b0;
    check("hold_done", out_valid_o, 0);

    // Reset during ADD discards the partial result
    a_drv = 32'h1111; b_drv = 32'h2222; cin_drv = 1'b0; in_valid_drv = 1'b1;
    @(posedge clk); #1;
    in_valid_drv = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_sum", sum_o, 0);
    check("mid_rst_ready", in_ready_o, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_valid", out_valid_o, 0);
    run(16, 32'h0003, 32'h0004, 1'b0, 32'h0007, 1'b0, 1'b0, 0);

    // WIDTH=4: a single ADD cycle
    run(4, 32'h9, 32'h8, 1'b1, 32'h2, 1'b1, 1'b0, 0);
    run(4, 32'hF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 1);
    run(4, 32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1'b0, 0);

    // WIDTH=32
    run(32, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 0);
    run(32, 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 3);
    run(32, 32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder that feeds the team's 4-bit ripple-carry adder one nibble per cycle, least-significant nibble first. Carry is registered between nibbles. Operands arrive on a valid/ready input handshake; the result leaves on a valid/ready output handshake. It is the sequencing stage around the combinational 4-bit adder, so wide additions need only one small adder.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NIBBLES, WIDTH/4, derived number of add cycles; not overridable

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  sum, cout, zero are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  a+b+cin modulo 2^WIDTH
cout  output  1  carry out of the MSB
zero  output  1  1 when sum == 0
busy  output  1  1 in ADD or DONE

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- On rst: state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; zero=0; busy=0; nibble index=0; internal operand registers=0.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture a and b into shift registers, set carry reg=cin, index=0, go to ADD.
- ADD:
  - in_ready=0.
  - Each edge: the low nibble of the A and B shift registers plus the carry reg drive the 4-bit adder.
  - The 4-bit result is shifted into sum from the MSB end; carry reg takes the adder's Cout.
  - The operand registers shift right by 4 and the index increments.
  - On the edge where index==NIBBLES-1, go to DONE; cout takes the final carry and zero is computed from the completed sum.
- DONE:
  - out_valid=1. sum, cout and zero are held stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid drops to 0.
  - sum, cout and zero keep their last value until the next transaction overwrites them.
- Latency: the acceptance edge is E0. out_valid is high in the cycle after edge E_NIBBLES (4 cycles for WIDTH=16).
- Minimum spacing between input acceptances: NIBBLES+2 cycles.
- Width rule: the final carry is cout; there is no overflow truncation beyond modulo 2^WIDTH.
- Boundary cases:
  - in_valid in ADD or DONE is ignored and not captured.
  - The out_ready value is ignored outside DONE.
  - out_ready and in_valid both high in DONE: complete the output handshake only; the new operand is accepted at the earliest on the following edge, from IDLE.
  - WIDTH=4: a single ADD cycle.
  - rst asserted mid-ADD or mid-DONE aborts immediately to the reset state; the partial result is discarded and out_valid=0 with no glitch after release.
  - Inputs are sampled only on the acceptance edge; changing a or b afterwards has no effect.

Decomposition:
- Shared package:
  - NIBBLE_W=4
  - state enum IDLE/ADD/DONE (2-bit encoding 00/01/10)
  - function computing the index width, clog2(NIBBLES) with a minimum of 1
- Sub-module: one instance of the existing 4-bit ripple-carry adder, bit_ripple_carry_adder, for the nibble datapath. Everything else (FSM, shift registers, handshake) is in this module.

Test Plan:
1. WIDTH=16: a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid 4 cycles after acceptance; sum=0x5555, cout=0, zero=0; in_ready returns to 1 the cycle after the output handshake.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1. Also a=0xFFFF, b=0x0000, cin=1 -> same result, proving carry ripples through all 4 nibbles.
3. Backpressure: a=0x8000, b=0x8000, out_ready=0 for 6 cycles after out_valid -> sum=0x0000, cout=1 held stable; out_valid stays 1; in_ready stays 0; then out_ready=1 completes in one cycle.
4. in_valid held high with changing a and b during ADD -> only the first operands are used (0x00FF+0x0001 gives 0x0100); the second operands are accepted only after returning to IDLE.
5. Reset mid-op: assert rst after 2 ADD cycles of 0x1111+0x2222 -> immediately out_valid=0, sum=0, in_ready=1; then a fresh 0x0003+0x0004 gives 0x0007.
6. Random regression with WIDTH=4, 16 and 32: back-to-back transactions with random out_ready -> every result equals the a+b+cin reference model; the latency check passes on every transaction.
